// File: rtl/dcache_pkg.sv
// Shared types for the L1 data cache: address split, frame layout and controller states.
package dcache_pkg;

    localparam int unsigned DC_SETS = 8;
    localparam int unsigned DC_IDXW = $clog2(DC_SETS);
    localparam int unsigned DC_TAGW = 32 - DC_IDXW - 3;

    typedef struct packed {
        logic [DC_TAGW-1:0] tag;
        logic [DC_IDXW-1:0] idx;
        logic               blkoff;
        logic [1:0]         bytoff;
    } dcachef_t;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [DC_TAGW-1:0] tag;
        logic [1:0][31:0]   data;
    } dframe_t;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, LD0, LD1, FLUSH, FLWB0, FLWB1, CNT, DONE
    } dstate_t;

endpackage

// File: rtl/dcache.sv
// Two-way set-associative write-back L1 data cache with LRU replacement and
// a halt-triggered flush that ends by storing the hit count to CNT_ADDR.
module dcache
    import dcache_pkg::*;
#(
    parameter int unsigned SETS     = DC_SETS,
    parameter logic [31:0] CNT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    // Frame layout is fixed by the package, so SETS must stay equal to DC_SETS.
    localparam int unsigned IDXW = $clog2(SETS);
    localparam logic [IDXW:0] FCNT_ONE = 1;

    dframe_t            frame_q [SETS][2];
    logic [SETS-1:0]    lru_q;
    logic [31:0]        hitcnt_q;
    logic               missflag_q;
    logic [IDXW:0]      fcnt_q;
    logic [DC_TAGW-1:0] mtag_q;
    logic [IDXW-1:0]    midx_q;
    logic               vway_q;
    dstate_t            state_q, state_d;

    dcachef_t        req_a;
    dframe_t         way0_f, way1_f, vict_f, miss_f, fl_f;
    logic            req, hit0, hit1, hit, vict_way;
    logic [IDXW-1:0] fl_set;
    logic            fl_way, fl_last;
    logic            unused_addr;

    always_comb begin
        req_a    = dcachef_t'(dmemaddr);
        req      = dmemREN | dmemWEN;
        way0_f   = frame_q[req_a.idx][0];
        way1_f   = frame_q[req_a.idx][1];
        hit0     = way0_f.valid && (way0_f.tag == req_a.tag);
        hit1     = way1_f.valid && (way1_f.tag == req_a.tag);
        hit      = hit0 | hit1;
        vict_way = lru_q[req_a.idx];
        vict_f   = frame_q[req_a.idx][vict_way];
        miss_f   = frame_q[midx_q][vway_q];
        // Flush counter walks frames as {set, way}, way in the low bit.
        fl_set   = fcnt_q[IDXW:1];
        fl_way   = fcnt_q[0];
        fl_f     = frame_q[fl_set][fl_way];
        fl_last  = &fcnt_q;
    end

    assign unused_addr = ^req_a.bytoff;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (halt)
                    state_d = FLUSH;
                else if (req && !hit)
                    state_d = (vict_f.valid && vict_f.dirty) ? WB0 : LD0;
            end
            WB0:   if (!dwait) state_d = WB1;
            WB1:   if (!dwait) state_d = LD0;
            LD0:   if (!dwait) state_d = LD1;
            LD1:   if (!dwait) state_d = IDLE;
            FLUSH: begin
                if (fl_f.valid && fl_f.dirty) state_d = FLWB0;
                else if (fl_last)             state_d = CNT;
            end
            FLWB0: if (!dwait) state_d = FLWB1;
            FLWB1: if (!dwait) state_d = fl_last ? CNT : FLUSH;
            CNT:   if (!dwait) state_d = DONE;
            DONE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        case (state_q)
            IDLE: begin
                if (req && !halt && hit) begin
                    dhit     = 1'b1;
                    dmemload = hit1 ? way1_f.data[req_a.blkoff] : way0_f.data[req_a.blkoff];
                end
            end
            WB0: begin
                dWEN   = 1'b1;
                daddr  = {miss_f.tag, midx_q, 3'b000};
                dstore = miss_f.data[0];
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {miss_f.tag, midx_q, 3'b100};
                dstore = miss_f.data[1];
            end
            LD0: begin
                dREN  = 1'b1;
                daddr = {mtag_q, midx_q, 3'b000};
            end
            LD1: begin
                dREN  = 1'b1;
                daddr = {mtag_q, midx_q, 3'b100};
            end
            FLWB0: begin
                dWEN   = 1'b1;
                daddr  = {fl_f.tag, fl_set, 3'b000};
                dstore = fl_f.data[0];
            end
            FLWB1: begin
                dWEN   = 1'b1;
                daddr  = {fl_f.tag, fl_set, 3'b100};
                dstore = fl_f.data[1];
            end
            CNT: begin
                dWEN   = 1'b1;
                daddr  = CNT_ADDR;
                dstore = hitcnt_q;
            end
            DONE:    flushed = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < 2; w++) begin
                    frame_q[s[IDXW-1:0]][w[0]].valid <= 1'b0;
                    frame_q[s[IDXW-1:0]][w[0]].dirty <= 1'b0;
                end
            end
            lru_q      <= '0;
            hitcnt_q   <= '0;
            missflag_q <= 1'b0;
            fcnt_q     <= '0;
            mtag_q     <= '0;
            midx_q     <= '0;
            vway_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !halt) begin
                        if (hit) begin
                            if (dmemWEN) begin
                                frame_q[req_a.idx][hit1].data[req_a.blkoff] <= dmemstore;
                                frame_q[req_a.idx][hit1].dirty              <= 1'b1;
                            end
                            lru_q[req_a.idx] <= ~hit1;
                            // The retry hit that closes a miss is not counted.
                            if (!missflag_q) hitcnt_q <= hitcnt_q + 32'd1;
                            missflag_q <= 1'b0;
                        end else begin
                            missflag_q <= 1'b1;
                            mtag_q     <= req_a.tag;
                            midx_q     <= req_a.idx;
                            vway_q     <= vict_way;
                        end
                    end
                end
                LD0: begin
                    if (!dwait) begin
                        frame_q[midx_q][vway_q].data[0] <= dload;
                        frame_q[midx_q][vway_q].valid   <= 1'b0;
                    end
                end
                LD1: begin
                    if (!dwait) begin
                        frame_q[midx_q][vway_q].data[1] <= dload;
                        frame_q[midx_q][vway_q].valid   <= 1'b1;
                        frame_q[midx_q][vway_q].dirty   <= 1'b0;
                        frame_q[midx_q][vway_q].tag     <= mtag_q;
                    end
                end
                FLUSH: begin
                    if (!(fl_f.valid && fl_f.dirty) && !fl_last) fcnt_q <= fcnt_q + FCNT_ONE;
                end
                FLWB1: begin
                    if (!dwait) begin
                        frame_q[fl_set][fl_way].dirty <= 1'b0;
                        if (!fl_last) fcnt_q <= fcnt_q + FCNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dcache.md
Name: dcache

Overview:
- L1 data cache between the pipeline's memory-stage request signals and the memory controller / bus arbiter.
- Two-way set-associative, write-back, write-allocate, two-word blocks, LRU replacement.
- On halt it writes back every dirty block, stores the hit count to a fixed address, then asserts flushed.
- Services one data request at a time. dhit is the only completion signal back to the pipeline.

Parameters:
SETS, 8, number of sets (power of two); index width IDXW = log2(SETS)
CNT_ADDR, 32'h00003100, address where the final hit count is written during flush

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
dmemREN  in  1  pipeline load request
dmemWEN  in  1  pipeline store request
dmemaddr  in  32  word-aligned request address
dmemstore  in  32  store data
halt  in  1  pipeline halted; level, held until reset
dhit  out  1  request completes this cycle
dmemload  out  32  load data, valid while dhit
flushed  out  1  flush complete; held until reset
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory address
dstore  out  32  memory write data
dload  in  32  memory read data
dwait  in  1  memory busy; a transfer completes in the cycle dwait=0 with dREN or dWEN high

Behaviour:
- Reset is asynchronous: nRST low clears valid, dirty, LRU and hit count, and sets state IDLE. Outputs are 0 during and after reset until a request arrives. Tag/data arrays need no reset.
- Address split: tag = addr[31:IDXW+3], idx = addr[IDXW+2:3], blkoff = addr[2]; addr[1:0] are ignored.
- Per frame: valid, dirty, tag, data[2]. Per set: lru bit, which names the least-recently-used way.
- IDLE, hit (valid && tag match in either way, dmemREN|dmemWEN, halt=0):
  - dhit=1 combinationally, same cycle.
  - Load: dmemload = matched word.
  - Store: the word and dirty=1 are updated at the next edge.
  - lru is set to the other way.
  - hitcnt increments unless missflag is set; missflag is cleared.
- dmemREN and dmemWEN high together: treated as a store.
- IDLE, miss: victim = lru way; set missflag.
  - Victim valid && dirty -> WB0.
  - Otherwise -> LD0.
  - dhit=0 throughout the miss.
- WB0: dWEN=1, daddr={victim tag, idx, 3'b000}, dstore=word0. Advances to WB1 when dwait=0.
- WB1: same as WB0 with daddr +4 and word1. Advances to LD0 when dwait=0.
- LD0: dREN=1, daddr={tag, idx, 3'b000}. Captures dload into word0 when dwait=0, then -> LD1.
- LD1: same as LD0 with daddr +4 into word1. On completion: valid=1, dirty=0, tag written. Returns to IDLE; the retried request then hits.
- halt while IDLE -> FLUSH.
- halt during a miss: the fill sequence completes first, then the next IDLE cycle goes to FLUSH. No dhit is given once halt is high.
- FLUSH:
  - A 1+IDXW-bit frame counter walks set 0 way 0, set 0 way 1, set 1 way 0, … in order.
  - Dirty and valid frames: two writes (word0, word1), each advancing on dwait=0; dirty is then cleared.
  - Clean frames: skipped in one cycle.
  - After the last frame -> CNT.
- CNT: dWEN=1, daddr=CNT_ADDR, dstore=hitcnt (32-bit, wraps). On dwait=0 -> DONE.
- DONE: flushed=1 and all memory requests 0. Stays until reset.
- At most one of dREN/dWEN is high in any cycle. daddr and dstore are stable while dwait=1.
- Reset mid-operation aborts any transfer. A partially filled frame stays invalid.

Decomposition:
- Add to the shared CPU types package:
  - dcachef_t: packed address struct {tag, idx, blkoff, bytoff}.
  - dframe_t: packed struct {valid, dirty, tag, data[2]}.
  - dstate_t: enum {IDLE, WB0, WB1, LD0, LD1, FLUSH, FLWB0, FLWB1, CNT, DONE}.
- Single module. The next-state / output logic is one combinational process; arrays, lru, hitcnt and counter live in one flop process. No sub-module.

Test Plan:
- Cold load 0x00000040, dload returns 0xAAAA0000/0xAAAA0004 with dwait=1 for 2 cycles each -> dREN addresses 0x40, 0x44; then dhit with dmemload=0xAAAA0000. Load 0x44 next -> dhit same cycle, 0xAAAA0004, no bus activity.
- Store 0x12345678 to 0x40 after fill -> single-cycle dhit, dREN=dWEN=0. Reload 0x40 -> 0x12345678.
- Fill 0x40 (way0) and 0x140 (way1, same set 0) with 0x40 dirty, then load 0x240 -> write-back 0x40/0x44 with correct data, then reads 0x240/0x244. 0x140 stays resident (lru).
- Halt with dirty blocks in sets 0 and 5, 3 counted hits -> writes only those four words in set/way order, then write 0x00000003 to 0x3100, then flushed=1 held.
- halt raised during LD0 -> LD1 completes, no dhit, flush follows, flushed asserted.
- nRST pulsed low during WB1 -> all outputs 0 immediately. A subsequent load of the same address misses.
